// File: rtl/fsm_pair_serializer_if.sv
// Parallel-in / serial-out handshake bundle for the pair-detection link transmitter.
interface fsm_pair_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned PCW = $clog2(WIDTH);

   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             ready;
   logic             ser_out;
   logic             ser_valid;
   logic             done;
   logic [PCW-1:0]   pair_cnt;

   modport master (
      output data_in,
      output load,
      input  ready,
      input  ser_out,
      input  ser_valid,
      input  done,
      input  pair_cnt
   );

   modport slave (
      input  data_in,
      input  load,
      output ready,
      output ser_out,
      output ser_valid,
      output done,
      output pair_cnt
   );
endinterface

// File: rtl/fsm_pair_serializer.sv
// Moore-FSM serializer: captures a parallel word, shifts it out one bit per clock,
// and reports how many adjacent equal-bit pairs the frame contained.
module fsm_pair_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   fsm_pair_serializer_if.slave bus
);
   localparam int unsigned CW  = $clog2(WIDTH) + 1;
   localparam int unsigned PCW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [PCW-1:0]   run_q, run_d;
   logic [PCW-1:0]   pair_q, pair_d;
   logic             ready_q, ready_d;
   logic             ser_q, ser_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             nxt_bit;

   // Next-state and next-output logic; outputs are the registered form of these.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      run_d     = run_q;
      pair_d    = pair_q;
      ready_d   = 1'b0;
      ser_d     = IDLE_LEVEL;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      nxt_bit   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (bus.load && ready_q) begin
               state_d   = S_SHIFT;
               shift_d   = bus.data_in;
               bit_cnt_d = '0;
               run_d     = '0;
               ser_d     = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
               valid_d   = 1'b1;
               ready_d   = 1'b0;
            end
         end

         S_SHIFT: begin
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pair_d  = run_q;
            end else begin
               // shift_q holds the bit on ser_out at its first-out end; peek the one after it
               nxt_bit   = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
               shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
               bit_cnt_d = bit_cnt_q + CW'(1);
               ser_d     = nxt_bit;
               valid_d   = 1'b1;
               if (nxt_bit == ser_q) begin
                  run_d = run_q + PCW'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         run_q     <= '0;
         pair_q    <= '0;
         ready_q   <= 1'b1;
         ser_q     <= IDLE_LEVEL;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         run_q     <= run_d;
         pair_q    <= pair_d;
         ready_q   <= ready_d;
         ser_q     <= ser_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.ser_out   = ser_q;
   assign bus.ser_valid = valid_q;
   assign bus.done      = done_q;
   assign bus.pair_cnt  = pair_q;
endmodule

// File: tb/tb_fsm_pair_serializer.sv
// Scoreboard bench for fsm_pair_serializer: an LSB-first and an MSB-first instance
// share clk/rst; expected bits and pair counts are queued at load time.
module tb_fsm_pair_serializer;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned PCW     = $clog2(WIDTH);
   localparam int          TIMEOUT = 40;
   localparam bit          IDLE    = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fsm_pair_serializer_if #(.WIDTH(WIDTH)) if_a ();
   fsm_pair_serializer_if #(.WIDTH(WIDTH)) if_b ();

   fsm_pair_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a.slave));
   fsm_pair_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b.slave));

   always #5 clk = ~clk;

   // Index 0 = LSB-first instance, index 1 = MSB-first instance
   logic             ld   [2];
   logic [WIDTH-1:0] din  [2];
   logic             rdy  [2];
   logic             so   [2];
   logic             sv   [2];
   logic             dn   [2];
   logic [PCW-1:0]   pc   [2];

   assign if_a.load    = ld[0];
   assign if_a.data_in = din[0];
   assign if_b.load    = ld[1];
   assign if_b.data_in = din[1];
   assign rdy[0] = if_a.ready;     assign rdy[1] = if_b.ready;
   assign so[0]  = if_a.ser_out;   assign so[1]  = if_b.ser_out;
   assign sv[0]  = if_a.ser_valid; assign sv[1]  = if_b.ser_valid;
   assign dn[0]  = if_a.done;      assign dn[1]  = if_b.done;
   assign pc[0]  = if_a.pair_cnt;  assign pc[1]  = if_b.pair_cnt;

   logic exp_bits  [2][$];
   int   exp_pairs [2][$];
   int   bits_seen [2];
   int   last_pair [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pairs_of(input logic [WIDTH-1:0] d);
      int n = 0;
      for (int k = 1; k < WIDTH; k++) if (d[k] == d[k-1]) n++;
      return n;
   endfunction

   task automatic push_frame(input int i, input logic [WIDTH-1:0] d);
      for (int k = 0; k < WIDTH; k++) exp_bits[i].push_back((i == 1) ? d[WIDTH-1-k] : d[k]);
      exp_pairs[i].push_back(pairs_of(d));
   endtask

   task automatic wait_ready(input int i);
      int n = 0;
      while (!rdy[i] && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(rdy[i]), 32'd1);
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dn[i] && n < TIMEOUT);
      check("done_seen", 32'(dn[i]), 32'd1);
   endtask

   // One-cycle load pulse; data_in is scrambled right after the accept edge
   task automatic start(input int i, input logic [WIDTH-1:0] d);
      wait_ready(i);
      din[i] = d;
      ld[i]  = 1'b1;
      push_frame(i, d);
      @(posedge clk);
      #1;
      ld[i]  = 1'b0;
      din[i] = ~d;
      @(negedge clk);
      check("first_bit_valid", 32'(sv[i]), 32'd1);
      check("busy_not_ready", 32'(rdy[i]), 32'd0);
   endtask

   // Output monitor: every frame bit, done pulse and pair count is scored here
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            bits_seen[i] = 0;
            last_pair[i] = 0;
         end else begin
            if (sv[i]) begin
               if (exp_bits[i].size() == 0) check("unexpected_bit", 32'(sv[i]), 32'd0);
               else check("ser_out", 32'(so[i]), 32'(exp_bits[i].pop_front()));
               bits_seen[i]++;
            end else begin
               check("idle_level", 32'(so[i]), 32'(IDLE));
            end
            if (dn[i]) begin
               check("bits_per_frame", 32'(bits_seen[i]), 32'(WIDTH));
               check("valid_done_exclusive", 32'(sv[i]), 32'd0);
               if (exp_pairs[i].size() == 0) check("unexpected_done", 32'(dn[i]), 32'd0);
               else check("pair_cnt", 32'(pc[i]), 32'(exp_pairs[i].pop_front()));
               bits_seen[i] = 0;
               last_pair[i] = int'(pc[i]);
            end else begin
               check("pair_cnt_hold", 32'(pc[i]), 32'(last_pair[i]));
            end
         end
      end
   end

   initial begin
      int  n;
      bit  got;

      for (int i = 0; i < 2; i++) begin
         ld[i] = 1'b1;
         din[i] = 8'hFF;
         bits_seen[i] = 0;
         last_pair[i] = 0;
      end

      // Reset held two edges with load asserted
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", 32'(rdy[i]), 32'd1);
         check("rst_ser_out", 32'(so[i]), 32'(IDLE));
         check("rst_ser_valid", 32'(sv[i]), 32'd0);
         check("rst_done", 32'(dn[i]), 32'd0);
         check("rst_pair_cnt", 32'(pc[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      ld[0] = 1'b0;
      ld[1] = 1'b0;

      // LSB-first A5
      start(0, 8'hA5);
      wait_done(0);
      check("a5_pairs", 32'(pc[0]), 32'd1);

      // Back-to-back FF then AA with load held high
      wait_ready(0);
      din[0] = 8'hFF;
      ld[0]  = 1'b1;
      push_frame(0, 8'hFF);
      @(posedge clk);
      #1;
      din[0] = 8'hAA;
      push_frame(0, 8'hAA);
      n = 0;
      got = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (dn[0]) begin
            got = 1'b1;
            check("ff_pairs", 32'(pc[0]), 32'd7);
         end
      end while (!rdy[0] && n < TIMEOUT);
      check("ff_done_seen", 32'(got), 32'd1);
      check("frame_period", 32'(n), 32'(WIDTH + 2));
      @(posedge clk);
      #1;
      ld[0] = 1'b0;
      wait_done(0);
      check("aa_pairs", 32'(pc[0]), 32'd0);

      // MSB-first 0F
      start(1, 8'h0F);
      wait_done(1);
      check("0f_msb_pairs", 32'(pc[1]), 32'd6);

      // Load pulse during SHIFT is ignored
      start(0, 8'hC3);
      repeat (2) @(negedge clk);
      din[0] = 8'h3C;
      ld[0]  = 1'b1;
      @(negedge clk);
      ld[0]  = 1'b0;
      wait_done(0);
      check("c3_pairs", 32'(pc[0]), 32'd5);
      repeat (12) @(negedge clk);
      check("c3_bits_drained", 32'(exp_bits[0].size()), 32'd0);

      // Reset at the 4th bit aborts the frame
      start(0, 8'h5A);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_bits[i].delete();
         exp_pairs[i].delete();
      end
      @(negedge clk);
      check("abort_ser_valid", 32'(sv[0]), 32'd0);
      check("abort_ready", 32'(rdy[0]), 32'd1);
      check("abort_pair_cnt", 32'(pc[0]), 32'd0);
      check("abort_done", 32'(dn[0]), 32'd0);
      check("abort_ser_out", 32'(so[0]), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      start(0, 8'h96);
      wait_done(0);
      check("post_abort_pairs", 32'(pc[0]), 32'd2);

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("final_bits_drained", 32'(exp_bits[i].size()), 32'd0);
         check("final_pairs_drained", 32'(exp_pairs[i].size()), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
